// File: rtl/jtframe_scan2x_core.sv
// Line doubler: stores each input line in a ping-pong buffer and replays the previous line twice.
// Optional macro JTFRAME_SCAN2X_SCANLINE_EN blanks the second replay pass (scanline effect).
module jtframe_scan2x_core #(
    parameter int DW   = 8,
    parameter int HLEN = 322
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          base_cen,
    input  logic          basex2_cen,
    input  logic [DW-1:0] base_pxl,
    input  logic          HS,
    output logic [DW-1:0] x2_pxl,
    output logic          x2_HS
);

    localparam int            AW   = (HLEN > 1) ? $clog2(HLEN) : 1;
    localparam logic [AW-1:0] LAST = AW'(HLEN - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    logic [DW-1:0] mem0 [HLEN];
    logic [DW-1:0] mem1 [HLEN];

    logic          sel;
    logic          pass;
    logic          hs_last;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    hs_cnt;
    logic [7:0]    hs_width;

    logic          hs_rise;
    logic          hs_fall;
    logic          wr_sel;
    logic [AW-1:0] wr_ptr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_pxl;

    assign hs_rise = base_cen &  HS & ~hs_last;
    assign hs_fall = base_cen & ~HS &  hs_last;

    // The pixel arriving with the sync edge already belongs to the new line and buffer
    assign wr_sel  = hs_rise ? ~sel : sel;
    assign wr_ptr  = hs_rise ? '0 : wr_addr;
    assign rd_data = sel ? mem0[rd_addr] : mem1[rd_addr];

`ifdef JTFRAME_SCAN2X_SCANLINE_EN
    assign out_pxl = pass ? '0 : rd_data;
`else
    assign out_pxl = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (base_cen) begin
            if (wr_sel) mem1[wr_ptr] <= base_pxl;
            else        mem0[wr_ptr] <= base_pxl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= 1'b0;
            pass     <= 1'b0;
            hs_last  <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            hs_cnt   <= 8'd0;
            hs_width <= 8'd0;
            x2_pxl   <= '0;
            x2_HS    <= 1'b0;
        end else begin
            if (base_cen) begin
                hs_last <= HS;
                if (HS) begin
                    if (hs_rise)             hs_cnt <= 8'd1;
                    else if (hs_cnt != 8'hFF) hs_cnt <= hs_cnt + 8'd1;
                end
                if (hs_fall) hs_width <= hs_cnt;
                // Address 0 is consumed by the boundary pixel, so writing resumes at 1
                if (hs_rise) begin
                    sel     <= ~sel;
                    wr_addr <= ONE;
                end else if (wr_addr != LAST) begin
                    wr_addr <= wr_addr + ONE;
                end
            end

            if (basex2_cen) begin
                x2_pxl <= out_pxl;
                x2_HS  <= (32'(rd_addr) < 32'(hs_width));
            end

            if (hs_rise) begin
                rd_addr <= '0;
                pass    <= 1'b0;
            end else if (basex2_cen) begin
                if (rd_addr == LAST) begin
                    if (!pass) begin
                        rd_addr <= '0;
                        pass    <= 1'b1;
                    end
                end else begin
                    rd_addr <= rd_addr + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_scan2x_core.sv
// Randomized bench for jtframe_scan2x_core against a line-level reference model.
// Honours JTFRAME_SCAN2X_SCANLINE_EN in the model when the macro is defined.
module tb_jtframe_scan2x_core;

    localparam int DW   = 8;
    localparam int HLEN = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          base_cen;
    logic          basex2_cen;
    logic [DW-1:0] base_pxl;
    logic          HS;
    logic [DW-1:0] x2_pxl;
    logic          x2_HS;

    int checks = 0;
    int fails  = 0;

    jtframe_scan2x_core #(.DW(DW), .HLEN(HLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .base_cen   (base_cen),
        .basex2_cen (basex2_cen),
        .base_pxl   (base_pxl),
        .HS         (HS),
        .x2_pxl     (x2_pxl),
        .x2_HS      (x2_HS)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expected, $time);
        end
    endtask

    // Reference model: two physical line stores, a write cursor and a replay index
    logic [DW-1:0]   m_mem [2][HLEN];
    bit   [HLEN-1:0] m_val [2];
    int              m_wsel, m_w, m_j, m_hw, m_cnt;
    bit              m_last;
    int              e_addr;
    bit              e_pass, e_hs, e_chk, m_rise, m_fall;
    logic [DW-1:0]   e_pxl;

    initial begin
        m_val[0] = '0;
        m_val[1] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_wsel = 0; m_w = 0; m_j = 0; m_hw = 0; m_cnt = 0; m_last = 0;
            end else begin
                e_chk = 0;
                e_hs  = 0;
                e_pxl = '0;
                if (basex2_cen) begin
                    // Replay index j walks two passes over the line, then sticks on the last entry
                    e_pass = (m_j >= HLEN);
                    if (m_j < HLEN)              e_addr = m_j;
                    else if (m_j - HLEN < HLEN)  e_addr = m_j - HLEN;
                    else                         e_addr = HLEN - 1;
                    e_hs  = (e_addr < m_hw);
                    e_pxl = m_mem[1 - m_wsel][e_addr];
                    e_chk = m_val[1 - m_wsel][e_addr];
`ifdef JTFRAME_SCAN2X_SCANLINE_EN
                    if (e_pass) begin
                        e_pxl = '0;
                        e_chk = 1;
                    end
`endif
                end
                m_rise = base_cen && HS && !m_last;
                m_fall = base_cen && !HS && m_last;
                if (base_cen) begin
                    if (HS) m_cnt = m_rise ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                    if (m_fall) m_hw = m_cnt;
                    m_last = HS;
                    if (m_rise) begin
                        m_wsel = 1 - m_wsel;
                        m_w    = 0;
                    end
                    m_mem[m_wsel][m_w] = base_pxl;
                    m_val[m_wsel][m_w] = 1'b1;
                    if (m_w < HLEN - 1) m_w++;
                end
                if (m_rise)          m_j = 0;
                else if (basex2_cen) m_j++;
                if (basex2_cen) begin
                    #1;
                    checkOutput("x2_HS", 32'(x2_HS), 32'(e_hs));
                    if (e_chk) checkOutput("x2_pxl", 32'(x2_pxl), 32'(e_pxl));
                end
            end
        end
    end

    // One input pixel period: base_cen on the first clock, basex2_cen on the first and third
    task automatic applyStimulus(input logic [DW-1:0] p, input logic h);
        @(negedge clk);
        base_cen   = 1'b1;
        basex2_cen = 1'b1;
        base_pxl   = p;
        HS         = h;
        @(negedge clk);
        base_cen   = 1'b0;
        basex2_cen = 1'b0;
        @(negedge clk);
        basex2_cen = 1'b1;
        @(negedge clk);
        basex2_cen = 1'b0;
    endtask

    task automatic sendLine(input int len, input int hsw, input bit ramp);
        for (int i = 0; i < len; i++)
            applyStimulus(ramp ? DW'(8'h10 + i) : DW'($urandom), (i < hsw));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int len, hsw;
        rst        = 1'b1;
        base_cen   = 1'b0;
        basex2_cen = 1'b0;
        base_pxl   = '0;
        HS         = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pxl", 32'(x2_pxl), 32'd0);
        checkOutput("reset_hs", 32'(x2_HS), 32'd0);
        rst = 1'b0;

        repeat (3) sendLine(16, 2, 1'b1);
        sendLine(20, 3, 1'b1);
        sendLine(16, 2, 1'b1);
        sendLine(3, 1, 1'b1);
        sendLine(16, 2, 1'b1);
        sendLine(16, 2, 1'b1);

        // Asynchronous reset in the middle of a line
        sendLine(6, 2, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_pxl", 32'(x2_pxl), 32'd0);
        checkOutput("midrst_hs", 32'(x2_HS), 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("hold_pxl", 32'(x2_pxl), 32'd0);
            checkOutput("hold_hs", 32'(x2_HS), 32'd0);
        end
        rst = 1'b0;

        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(3, 20);
            hsw = $urandom_range(1, (len > 5) ? 5 : len - 1);
            sendLine(len, hsw, 1'b0);
        end

        // A sync pulse longer than 255 pixels saturates the width counter
        sendLine(300, 260, 1'b0);
        sendLine(16, 2, 1'b1);
        sendLine(16, 2, 1'b1);
        sendLine(16, 2, 1'b0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
